// File: rtl/cdma_u_wr_splitter_pkg.sv
// Shared types and constants for the unaligned-write CDMA request splitter.
//   CDMA_CHUNK_BITS  : log2 of the chunk size; sub-writes never cross a chunk boundary
//   wr_split_state_t : splitter FSM state encoding
package cdma_u_wr_splitter_pkg;

  localparam int unsigned CDMA_CHUNK_BITS = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_CPL
  } wr_split_state_t;

endpackage

// File: rtl/cdma_chunk_calc.sv
// Length of the next chunk: the smaller of the bytes left and the room up to the
// next 2**CHUNK_BITS boundary.
//   addr_lo      in   CHUNK_BITS      low bits of the current byte address
//   remaining    in   REQ_LEN_BITS    bytes still to be issued
//   chunk_len_c  out  CHUNK_BITS+1    chunk length (combinational), 1..2**CHUNK_BITS when remaining != 0
module cdma_chunk_calc #(
  parameter int unsigned CHUNK_BITS   = 12,
  parameter int unsigned REQ_LEN_BITS = 32
) (
  input  logic [CHUNK_BITS-1:0]   addr_lo,
  input  logic [REQ_LEN_BITS-1:0] remaining,
  output logic [CHUNK_BITS:0]     chunk_len_c
);

  localparam int unsigned CW = CHUNK_BITS + 1;

  logic [CW-1:0] room_c;

  // Room to the boundary is held in CHUNK_BITS+1 bits so an aligned address yields a full chunk.
  always_comb begin
    room_c = (CW'(1) << CHUNK_BITS) - CW'(addr_lo);
    if (remaining < REQ_LEN_BITS'(room_c)) begin
      chunk_len_c = CW'(remaining);
    end else begin
      chunk_len_c = room_c;
    end
  end

endmodule

// File: rtl/cdma_u_wr_splitter.sv
// Splits one large write request into chunk-aligned CDMA write descriptors, bounds the
// number of in-flight chunks, and returns one completion per request after every chunk's
// wr_done has come back.
//   aclk, areset            clock, asynchronous active-high reset
//   s_req_valid/ready       request handshake (ready only in IDLE)
//   s_req_addr/len/tag      start byte address, total bytes (0 legal), completion tag
//   wr_valid/ready          chunk descriptor handshake (registered valid)
//   wr_paddr/len            chunk address and byte count (registered)
//   wr_done                 one-cycle pulse per completed chunk
//   cpl_valid/ready/tag     request completion handshake and its tag
//   err_unexp               sticky: wr_done seen with nothing outstanding
module cdma_u_wr_splitter
  import cdma_u_wr_splitter_pkg::*;
#(
  parameter int unsigned ADDR_BITS       = 64,
  parameter int unsigned LEN_BITS        = 28,
  parameter int unsigned REQ_LEN_BITS    = 32,
  parameter int unsigned CHUNK_BITS      = CDMA_CHUNK_BITS,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned TAG_BITS        = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    s_req_valid,
  output logic                    s_req_ready,
  input  logic [ADDR_BITS-1:0]    s_req_addr,
  input  logic [REQ_LEN_BITS-1:0] s_req_len,
  input  logic [TAG_BITS-1:0]     s_req_tag,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [ADDR_BITS-1:0]    wr_paddr,
  output logic [LEN_BITS-1:0]     wr_len,
  input  logic                    wr_done,
  output logic                    cpl_valid,
  input  logic                    cpl_ready,
  output logic [TAG_BITS-1:0]     cpl_tag,
  output logic                    err_unexp
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW    = CHUNK_BITS + 1;

  wr_split_state_t         state_q, state_d;
  logic [ADDR_BITS-1:0]    cur_addr_q, cur_addr_d;
  logic [REQ_LEN_BITS-1:0] remaining_q, remaining_d;
  logic [OUT_W-1:0]        outstanding_q, outstanding_d;

  logic                    s_req_ready_d;
  logic                    wr_valid_d;
  logic [ADDR_BITS-1:0]    wr_paddr_d;
  logic [LEN_BITS-1:0]     wr_len_d;
  logic                    cpl_valid_d;
  logic [TAG_BITS-1:0]     cpl_tag_d;
  logic                    err_unexp_d;

  logic                    req_hs_c;
  logic                    wr_hs_c;
  logic                    done_ok_c;
  logic [OUT_W:0]          occ_c;
  logic                    issue_room_c;
  logic [CW-1:0]           chunk_len_c;

  assign req_hs_c  = s_req_valid && s_req_ready;
  assign wr_hs_c   = wr_valid && wr_ready;
  assign done_ok_c = wr_done && (outstanding_q != '0);

  // Full check uses the registered count plus this cycle's handshake; a same-cycle wr_done is ignored.
  assign occ_c        = {1'b0, outstanding_q} + (OUT_W + 1)'(wr_hs_c);
  assign issue_room_c = occ_c < (OUT_W + 1)'(MAX_OUTSTANDING);

  // Chunk for the position that will be current after this edge, so the next
  // descriptor is ready back-to-back with the handshake.
  cdma_chunk_calc #(
    .CHUNK_BITS  (CHUNK_BITS),
    .REQ_LEN_BITS(REQ_LEN_BITS)
  ) u_chunk_calc (
    .addr_lo    (cur_addr_d[CHUNK_BITS-1:0]),
    .remaining  (remaining_d),
    .chunk_len_c(chunk_len_c)
  );

  // Next state, position, outstanding count and completion/error outputs.
  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    outstanding_d = outstanding_q;
    cpl_valid_d   = cpl_valid;
    cpl_tag_d     = cpl_tag;
    err_unexp_d   = err_unexp || (wr_done && (outstanding_q == '0));

    case ({wr_hs_c, done_ok_c})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (req_hs_c) begin
          cur_addr_d  = s_req_addr;
          remaining_d = s_req_len;
          cpl_tag_d   = s_req_tag;
          if (s_req_len == '0) begin
            state_d     = ST_CPL;
            cpl_valid_d = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (wr_hs_c) begin
          cur_addr_d  = cur_addr_q + ADDR_BITS'(wr_len);
          remaining_d = remaining_q - REQ_LEN_BITS'(wr_len);
          if (remaining_d == '0) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (outstanding_d == '0) begin
          state_d     = ST_CPL;
          cpl_valid_d = 1'b1;
        end
      end
      ST_CPL: begin
        if (cpl_valid && cpl_ready) begin
          state_d     = ST_IDLE;
          cpl_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    s_req_ready_d = (state_d == ST_IDLE);
  end

  // Descriptor register: an offered descriptor is held until accepted.
  always_comb begin
    wr_valid_d = wr_valid;
    wr_paddr_d = wr_paddr;
    wr_len_d   = wr_len;
    if (!wr_valid || wr_ready) begin
      wr_valid_d = (state_d == ST_ISSUE) && (remaining_d != '0) && issue_room_c;
      if (wr_valid_d) begin
        wr_paddr_d = cur_addr_d;
        wr_len_d   = LEN_BITS'(chunk_len_c);
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q       <= ST_IDLE;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      s_req_ready   <= 1'b0;
      wr_valid      <= 1'b0;
      wr_paddr      <= '0;
      wr_len        <= '0;
      cpl_valid     <= 1'b0;
      cpl_tag       <= '0;
      err_unexp     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      s_req_ready   <= s_req_ready_d;
      wr_valid      <= wr_valid_d;
      wr_paddr      <= wr_paddr_d;
      wr_len        <= wr_len_d;
      cpl_valid     <= cpl_valid_d;
      cpl_tag       <= cpl_tag_d;
      err_unexp     <= err_unexp_d;
    end
  end

endmodule
